// File: rtl/out_word_serializer.sv
// out_word_serializer: captures a wide vector and streams it out as 32-bit words, least-significant slice first.
module out_word_serializer #(
  parameter int OUT_W = 96,
  parameter int WORD_W = 32,
  localparam int NW = (OUT_W + WORD_W - 1) / WORD_W,
  localparam int IW = $clog2(NW) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cap_valid_i,
  input  logic [OUT_W-1:0]  cap_data_i,
  output logic              cap_ready_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [WORD_W-1:0] word_data_o,
  output logic [IW-1:0]     word_idx_o,
  output logic              word_last_o,
  input  logic              flush_i,
  output logic [15:0]       frame_cnt_o
);
  localparam int AW = NW > 1 ? $clog2(NW) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q;
  logic [WORD_W-1:0] data_q [NW];
  logic [NW*WORD_W-1:0] cap_wide;
  logic is_last, word_fire, last_fire, cap_fire;
  // Zero-extend so the top word's unused bits read as zero.
  assign cap_wide = (NW*WORD_W)'(cap_data_i);
  assign is_last = idx_q == AW'(NW - 1);
  always_comb begin
    word_valid_o = state_q == SEND;
    word_last_o = word_valid_o && is_last;
    word_data_o = word_valid_o ? data_q[idx_q] : '0;
    word_idx_o = IW'(idx_q);
    cap_ready_o = !word_valid_o || (word_ready_i && is_last);
  end
  assign word_fire = word_valid_o && word_ready_i;
  assign last_fire = word_fire && is_last;
  assign cap_fire = cap_valid_i && cap_ready_o;
  always_comb begin
    state_d = flush_i ? IDLE : cap_fire ? SEND : last_fire ? IDLE : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Flush wins over both a completing word and a new capture.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q <= '0;
      frame_cnt_o <= '0;
      for (int k = 0; k < NW; k++) data_q[k] <= '0;
    end else if (flush_i) begin
      idx_q <= '0;
    end else begin
      if (last_fire) frame_cnt_o <= frame_cnt_o + 16'd1;
      if (cap_fire || last_fire) idx_q <= '0;
      else if (word_fire) idx_q <= idx_q + AW'(1);
      if (cap_fire) for (int k = 0; k < NW; k++) data_q[k] <= cap_wide[k*WORD_W +: WORD_W];
    end
  end
endmodule

// File: tb/tb_out_word_serializer.sv
// tb_out_word_serializer: table-driven, hand-sequenced and randomized model checks of out_word_serializer.
module tb_out_word_serializer;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic a_cv = 0, a_wr = 0, a_fl = 0, a_cr, a_v, a_l;
  logic [95:0] a_cd = '0;
  logic [31:0] a_d;
  logic [2:0] a_i;
  logic [15:0] a_cnt;
  logic b_cv = 0, b_wr = 0, b_fl = 0, b_cr, b_v, b_l;
  logic [39:0] b_cd = '0;
  logic [31:0] b_d;
  logic [1:0] b_i;
  logic [15:0] b_cnt;
  logic c_cv = 0, c_wr = 0, c_fl = 0, c_cr, c_v, c_l;
  logic [31:0] c_cd = '0, c_d;
  logic [0:0] c_i;
  logic [15:0] c_cnt;

  out_word_serializer #(.OUT_W(96)) u96 (.clk_i(clk), .rst_ni(rst_n), .cap_valid_i(a_cv), .cap_data_i(a_cd),
    .cap_ready_o(a_cr), .word_valid_o(a_v), .word_ready_i(a_wr), .word_data_o(a_d), .word_idx_o(a_i),
    .word_last_o(a_l), .flush_i(a_fl), .frame_cnt_o(a_cnt));
  out_word_serializer #(.OUT_W(40)) u40 (.clk_i(clk), .rst_ni(rst_n), .cap_valid_i(b_cv), .cap_data_i(b_cd),
    .cap_ready_o(b_cr), .word_valid_o(b_v), .word_ready_i(b_wr), .word_data_o(b_d), .word_idx_o(b_i),
    .word_last_o(b_l), .flush_i(b_fl), .frame_cnt_o(b_cnt));
  out_word_serializer #(.OUT_W(32)) u32 (.clk_i(clk), .rst_ni(rst_n), .cap_valid_i(c_cv), .cap_data_i(c_cd),
    .cap_ready_o(c_cr), .word_valid_o(c_v), .word_ready_i(c_wr), .word_data_o(c_d), .word_idx_o(c_i),
    .word_last_o(c_l), .flush_i(c_fl), .frame_cnt_o(c_cnt));

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit cv; logic [95:0] cd; bit wr; bit fl;
    bit ev; logic [31:0] ed; int ei; bit el; bit ecr; int ecnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void r(bit cv, logic [95:0] cd, bit wr, bit fl, bit ev, logic [31:0] ed, int ei, bit el, bit ecr, int ecnt);
    tbl.push_back('{cv, cd, wr, fl, ev, ed, ei, el, ecr, ecnt});
  endfunction

  // Frame-level reference: a frame is a word list walked by position k.
  typedef struct { bit busy; logic [127:0] fr; int k; int cnt; } model_t;

  function automatic void m_out(input model_t m, input int nw, input bit wr, output bit v,
                                output logic [31:0] d, output int idx, output bit last, output bit cr);
    v = m.busy;
    d = 32'(m.fr >> (32 * m.k));
    idx = m.k;
    last = m.busy && (m.k == nw - 1);
    cr = !m.busy || (wr && last);
  endfunction

  function automatic model_t m_step(input model_t m, input int nw, input bit cv, input logic [127:0] cd,
                                    input bit wr, input bit fl);
    bit v, last, cr, done;
    logic [31:0] d;
    int idx;
    m_out(m, nw, wr, v, d, idx, last, cr);
    if (fl) begin
      m.busy = 0;
      m.k = 0;
      return m;
    end
    done = v && wr && last;
    if (done) m.cnt = (m.cnt + 1) % 65536;
    else if (v && wr) m.k++;
    if (cv && cr) begin
      m.fr = cd;
      m.k = 0;
      m.busy = 1;
    end else if (done) begin
      m.busy = 0;
      m.k = 0;
    end
    return m;
  endfunction

  localparam logic [95:0] D1 = 96'h33333333_22222222_11111111;
  localparam logic [95:0] D2 = 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA;

  initial begin
    model_t ma, mb;
    bit v, l, cr;
    logic [31:0] d, ew;
    int idx;

    tick;
    tick;
    chk("rst_valid", a_v, 0);
    chk("rst_last", a_l, 0);
    chk("rst_data", a_d, 0);
    chk("rst_cnt", a_cnt, 0);
    rst_n = 1;
    #1;
    chk("rst_cap_ready", a_cr, 1);
    tick;

    // basic frame, back-pressure, back-to-back, flush cases
    r(1, D1, 1, 0, 0, 0, 0, 0, 1, 0);
    r(0, 0, 1, 0, 1, 32'h11111111, 0, 0, 0, 0);
    r(0, 0, 1, 0, 1, 32'h22222222, 1, 0, 0, 0);
    r(0, 0, 1, 0, 1, 32'h33333333, 2, 1, 1, 0);
    r(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    r(1, D1, 0, 0, 0, 0, 0, 0, 1, 1);
    r(0, 0, 1, 0, 1, 32'h11111111, 0, 0, 0, 1);
    r(0, 0, 0, 0, 1, 32'h22222222, 1, 0, 0, 1);
    r(0, 0, 0, 0, 1, 32'h22222222, 1, 0, 0, 1);
    r(0, 0, 0, 0, 1, 32'h22222222, 1, 0, 0, 1);
    r(0, 0, 1, 0, 1, 32'h22222222, 1, 0, 0, 1);
    r(1, D2, 1, 0, 1, 32'h33333333, 2, 1, 1, 1);
    r(0, 0, 1, 0, 1, 32'hAAAAAAAA, 0, 0, 0, 2);
    r(1, D1, 1, 0, 1, 32'hBBBBBBBB, 1, 0, 0, 2);
    r(0, 0, 1, 0, 1, 32'hCCCCCCCC, 2, 1, 1, 2);
    r(0, 0, 1, 0, 0, 0, 0, 0, 1, 3);
    r(1, D1, 1, 0, 0, 0, 0, 0, 1, 3);
    r(0, 0, 1, 0, 1, 32'h11111111, 0, 0, 0, 3);
    r(0, 0, 0, 1, 1, 32'h22222222, 1, 0, 0, 3);
    r(0, 0, 1, 0, 0, 0, 0, 0, 1, 3);
    r(1, D2, 1, 0, 0, 0, 0, 0, 1, 3);
    r(0, 0, 1, 0, 1, 32'hAAAAAAAA, 0, 0, 0, 3);
    r(0, 0, 1, 0, 1, 32'hBBBBBBBB, 1, 0, 0, 3);
    r(1, D1, 1, 1, 1, 32'hCCCCCCCC, 2, 1, 1, 3);
    r(0, 0, 1, 0, 0, 0, 0, 0, 1, 3);
    r(1, D1, 1, 1, 0, 0, 0, 0, 1, 3);
    r(0, 0, 1, 0, 0, 0, 0, 0, 1, 3);
    for (int i = 0; i < tbl.size(); i++) begin
      a_cv = tbl[i].cv;
      a_cd = tbl[i].cd;
      a_wr = tbl[i].wr;
      a_fl = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_valid", i), a_v, tbl[i].ev);
      chk($sformatf("tbl%0d_last", i), a_l, tbl[i].el);
      chk($sformatf("tbl%0d_cap_ready", i), a_cr, tbl[i].ecr);
      chk($sformatf("tbl%0d_cnt", i), a_cnt, 64'(tbl[i].ecnt));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), a_d, tbl[i].ed);
        chk($sformatf("tbl%0d_idx", i), a_i, 64'(tbl[i].ei));
      end
      tick;
    end
    a_cv = 0;
    a_fl = 0;

    // reset mid-frame at idx 2
    a_cv = 1; a_cd = D1; a_wr = 1;
    tick;
    a_cv = 0;
    tick;
    tick;
    a_wr = 0;
    #1;
    chk("mid_idx", a_i, 2);
    rst_n = 0;
    tick;
    chk("mid_rst_valid", a_v, 0);
    chk("mid_rst_last", a_l, 0);
    chk("mid_rst_data", a_d, 0);
    chk("mid_rst_idx", a_i, 0);
    chk("mid_rst_cnt", a_cnt, 0);
    rst_n = 1;
    #1;
    chk("mid_rst_cap_ready", a_cr, 1);
    tick;
    chk("mid_after_valid", a_v, 0);
    chk("mid_after_cnt", a_cnt, 0);

    // padding with OUT_W=40
    b_cv = 1; b_cd = 40'hAB_12345678; b_wr = 1;
    tick;
    b_cv = 0;
    #1;
    chk("pad_w0_data", b_d, 32'h12345678);
    chk("pad_w0_idx", b_i, 0);
    chk("pad_w0_last", b_l, 0);
    tick;
    chk("pad_w1_data", b_d, 32'h000000AB);
    chk("pad_w1_idx", b_i, 1);
    chk("pad_w1_last", b_l, 1);
    tick;
    chk("pad_done_valid", b_v, 0);
    chk("pad_done_cnt", b_cnt, 1);

    // randomized run against the frame model
    rst_n = 0;
    tick;
    rst_n = 1;
    ma = '{busy: 0, fr: '0, k: 0, cnt: 0};
    mb = ma;
    for (int i = 0; i < 1500; i++) begin
      a_cv = 1'($urandom_range(0, 1));
      a_cd = {$urandom, $urandom, $urandom};
      a_wr = $urandom_range(0, 3) != 0;
      a_fl = $urandom_range(0, 19) == 0;
      b_cv = 1'($urandom_range(0, 1));
      b_cd = 40'({$urandom, $urandom});
      b_wr = $urandom_range(0, 3) != 0;
      b_fl = $urandom_range(0, 19) == 0;
      #1;
      m_out(ma, 3, a_wr, v, d, idx, l, cr);
      chk("rnd96_valid", a_v, v);
      chk("rnd96_last", a_l, l);
      chk("rnd96_cap_ready", a_cr, cr);
      chk("rnd96_cnt", a_cnt, 64'(ma.cnt));
      if (v) begin
        chk("rnd96_data", a_d, d);
        chk("rnd96_idx", a_i, 64'(idx));
      end
      m_out(mb, 2, b_wr, v, d, idx, l, cr);
      chk("rnd40_valid", b_v, v);
      chk("rnd40_last", b_l, l);
      chk("rnd40_cap_ready", b_cr, cr);
      chk("rnd40_cnt", b_cnt, 64'(mb.cnt));
      if (v) begin
        chk("rnd40_data", b_d, d);
        chk("rnd40_idx", b_i, 64'(idx));
      end
      @(posedge clk);
      ma = m_step(ma, 3, a_cv, 128'(a_cd), a_wr, a_fl);
      mb = m_step(mb, 2, b_cv, 128'(b_cd), b_wr, b_fl);
      #1;
    end
    a_cv = 0; a_fl = 0; b_cv = 0; b_fl = 0;

    // NW=1: one frame per cycle, counter wraps after 65536 frames
    rst_n = 0;
    tick;
    rst_n = 1;
    c_cv = 1; c_wr = 1; c_cd = 32'h5A5A0001;
    tick;
    c_wr = 0;
    #1;
    chk("nw1_last", c_l, 1);
    chk("nw1_idx", c_i, 0);
    chk("nw1_cap_ready_hold", c_cr, 0);
    chk("nw1_data", c_d, 32'h5A5A0001);
    c_wr = 1;
    for (int n = 1; n <= 65535; n++) begin
      c_cd = $urandom;
      ew = c_cd;
      tick;
      if (n % 8192 == 0) begin
        chk("nw1_stream_data", c_d, ew);
        chk("nw1_stream_cnt", c_cnt, 64'(n));
        chk("nw1_stream_last", c_l, 1);
      end
    end
    chk("wrap_ffff", c_cnt, 16'hFFFF);
    c_cv = 0;
    tick;
    chk("wrap_zero", c_cnt, 0);
    chk("wrap_idle", c_v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
